// File: rtl/hub_row_loader.sv
// Byte-stream to full-width row writer for the HUB75 pixel RAMs.
// Define HUB_ROW_LOADER_DOUBLE_BUFFER_EN for gap-free ping-pong row buffering.
module hub_row_loader #(
  parameter int COLOR_BITS    = 8,
  parameter int ROW_ADDR_BITS = 6,
  parameter int COL_ADDR_BITS = 4,
  parameter int PLANES        = 6
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [COLOR_BITS-1:0]                      in_data,
  input  logic                                       in_valid,
  input  logic                                       in_sof,
  output logic                                       in_ready,
  output logic [PLANES-1:0]                          ram_wen,
  output logic [COL_ADDR_BITS-1:0]                   ram_waddr,
  output logic [(2**ROW_ADDR_BITS)*COLOR_BITS-1:0]   ram_wdata,
  output logic                                       frame_done,
  output logic                                       sof_err
);

  localparam int NPIX = 2**ROW_ADDR_BITS;
  localparam int W    = NPIX * COLOR_BITS;
  localparam int PW   = (PLANES > 1) ? $clog2(PLANES) : 1;
  localparam logic [PW-1:0] PLANE_LAST = PW'(PLANES - 1);

  localparam logic [0:0] FILL   = 1'b0;
  localparam logic [0:0] COMMIT = 1'b1;

  logic [0:0]               state;
  logic [ROW_ADDR_BITS-1:0] pix_cnt;
  logic [COL_ADDR_BITS-1:0] row_cnt;
  logic [PW-1:0]            plane_cnt;
  logic [PLANES-1:0]        wen_q;
  logic [ROW_ADDR_BITS-1:0] slot;

  logic accept;
  logic last_pix;
  logic last_row;
  logic last_plane;
  logic aligned;
  logic row_end;

`ifdef HUB_ROW_LOADER_DOUBLE_BUFFER_EN
  assign in_ready = ~rst;
`else
  assign in_ready = ~rst & (state == FILL);
`endif

  assign accept     = in_valid & in_ready;
  assign last_pix   = &pix_cnt;
  assign last_row   = &row_cnt;
  assign last_plane = (plane_cnt == PLANE_LAST);
  assign aligned    = (pix_cnt == '0) & (row_cnt == '0) & (plane_cnt == '0);
  assign row_end    = accept & ~in_sof & last_pix;
  assign slot       = in_sof ? '0 : pix_cnt;
  assign ram_wen    = (state == COMMIT) ? wen_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      pix_cnt    <= '0;
      row_cnt    <= '0;
      plane_cnt  <= '0;
      wen_q      <= '0;
      ram_waddr  <= '0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      state      <= FILL;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
      if (accept) begin
        if (in_sof) begin
          // SOF realigns; any partial row is dropped unwritten
          sof_err   <= ~aligned;
          pix_cnt   <= ROW_ADDR_BITS'(1);
          row_cnt   <= '0;
          plane_cnt <= '0;
        end else begin
          pix_cnt <= pix_cnt + ROW_ADDR_BITS'(1);
          if (last_pix) begin
            state      <= COMMIT;
            wen_q      <= PLANES'(1) << plane_cnt;
            ram_waddr  <= row_cnt;
            frame_done <= last_row & last_plane;
            row_cnt    <= row_cnt + COL_ADDR_BITS'(1);
            if (last_row)
              plane_cnt <= last_plane ? '0 : plane_cnt + PW'(1);
          end
        end
      end
    end
  end

`ifdef HUB_ROW_LOADER_DOUBLE_BUFFER_EN
  logic         fill_sel;
  logic         commit_sel;
  logic [W-1:0] buf0;
  logic [W-1:0] buf1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_sel   <= 1'b0;
      commit_sel <= 1'b0;
    end else if (row_end) begin
      fill_sel   <= ~fill_sel;
      commit_sel <= fill_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (fill_sel)
        buf1[int'(slot)*COLOR_BITS +: COLOR_BITS] <= in_data;
      else
        buf0[int'(slot)*COLOR_BITS +: COLOR_BITS] <= in_data;
    end
  end

  assign ram_wdata = commit_sel ? buf1 : buf0;
`else
  logic [W-1:0] buf0;

  // in_ready is low during COMMIT, so the buffer is stable while written out
  always_ff @(posedge clk) begin
    if (accept)
      buf0[int'(slot)*COLOR_BITS +: COLOR_BITS] <= in_data;
  end

  assign ram_wdata = buf0;
`endif

endmodule

// File: tb/tb_hub_row_loader.sv
// Scoreboard bench for hub_row_loader: model pushes expected row
// writes on each accepted byte, monitor pops them on ram_wen.
module tb_hub_row_loader;

  typedef struct packed {
    logic [5:0]   wen;
    logic [3:0]   addr;
    logic [511:0] data;
    logic         fd;
  } wr_t;

`ifdef HUB_ROW_LOADER_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic         in_ready;
  logic [5:0]   ram_wen;
  logic [3:0]   ram_waddr;
  logic [511:0] ram_wdata;
  logic         frame_done;
  logic         sof_err;

  always #5 clk = ~clk;

  hub_row_loader dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .ram_wen    (ram_wen),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  int checks  = 0;
  int errors  = 0;
  int wr_cnt  = 0;
  int fd_cnt  = 0;
  int sof_cnt = 0;
  int exp_sof = 0;
  int cyc     = 0;

  int           m_pl = 0;
  int           m_rw = 0;
  int           m_px = 0;
  logic [511:0] m_row = '0;
  wr_t          sb[$];

  task automatic chk(input string tag, input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_accept(input logic [7:0] d, input logic s);
    wr_t w;
    if (s) begin
      if (m_px != 0 || m_rw != 0 || m_pl != 0) exp_sof++;
      m_row[7:0] = d;
      m_px = 1;
      m_rw = 0;
      m_pl = 0;
    end else begin
      m_row[m_px*8 +: 8] = d;
      if (m_px == 63) begin
        w.wen  = 6'(1 << m_pl);
        w.addr = 4'(m_rw);
        w.data = m_row;
        w.fd   = (m_pl == 5) && (m_rw == 15);
        sb.push_back(w);
        m_px = 0;
        if (m_rw == 15) begin
          m_rw = 0;
          m_pl = (m_pl == 5) ? 0 : m_pl + 1;
        end else begin
          m_rw++;
        end
      end else begin
        m_px++;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] d, input logic s, input int maxgap);
    int n;
    int g;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (g) begin
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = s;
    n = 0;
    while (!in_ready && n < 8) begin
      @(negedge clk);
      n++;
      cyc++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 512'(in_ready), 512'(1));
      in_valid = 1'b0;
      in_sof   = 1'b0;
      return;
    end
    model_accept(d, s);
    @(negedge clk);
    cyc++;
    in_valid = 1'b0;
    in_sof   = 1'b1;
    in_data  = 8'($urandom);
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 512'(in_ready), 512'(0));
    chk("rst_wen", 512'(ram_wen), 512'(0));
    chk("rst_fd", 512'(frame_done), 512'(0));
    chk("rst_soferr", 512'(sof_err), 512'(0));
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    m_px = 0;
    m_rw = 0;
    m_pl = 0;
    @(negedge clk);
    chk("rst_rel_ready", 512'(in_ready), 512'(1));
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    chk(tag, 512'(sb.size()), 512'(0));
  endtask

  always @(negedge clk) begin : mon
    wr_t w;
    if (!rst) begin
      if (sof_err) sof_cnt++;
      if (frame_done) fd_cnt++;
      if (ram_wen != '0) begin
        wr_cnt++;
        if (sb.size() == 0) begin
          chk("wr_unexpected", 512'(ram_wen), 512'(0));
        end else begin
          w = sb.pop_front();
          chk("wen", 512'(ram_wen), 512'(w.wen));
          chk("waddr", 512'(ram_waddr), 512'(w.addr));
          chk("wdata", ram_wdata, w.data);
          chk("frame_done", 512'(frame_done), 512'(w.fd));
          chk("ready_commit", 512'(in_ready), 512'(DB));
        end
      end else if (frame_done) begin
        chk("fd_stray", 512'(frame_done), 512'(0));
      end
    end
  end

  initial begin
    int w0;
    int f0;
    int s0;
    int n5;

    // single row with SOF on pixel 0
    do_reset();
    w0 = wr_cnt;
    s0 = sof_cnt;
    for (int i = 0; i < 64; i++) send(8'(i), i == 0, 0);
    drain("t1_queue");
    chk("t1_writes", 512'(wr_cnt - w0), 512'(1));
    chk("t1_soferr", 512'(sof_cnt - s0), 512'(0));

    // full frame, gap-free, throughput
    do_reset();
    w0  = wr_cnt;
    f0  = fd_cnt;
    cyc = 0;
    for (int i = 0; i < 6144; i++) send(8'hA5, i == 0, 0);
    chk("t2_cycles", 512'(cyc), 512'(DB ? 6144 : 6239));
    drain("t2_queue");
    chk("t2_writes", 512'(wr_cnt - w0), 512'(96));
    chk("t2_frame_done", 512'(fd_cnt - f0), 512'(1));

    // misaligned SOF drops partial row
    do_reset();
    w0 = wr_cnt;
    s0 = sof_cnt;
    exp_sof = 0;
    for (int i = 0; i < 10; i++) send(8'($urandom), 1'b0, 0);
    send(8'h77, 1'b1, 0);
    for (int i = 0; i < 63; i++) send(8'($urandom), 1'b0, 0);
    drain("t3_queue");
    chk("t3_soferr", 512'(sof_cnt - s0), 512'(1));
    chk("t3_soferr_model", 512'(sof_cnt - s0), 512'(exp_sof));
    chk("t3_writes", 512'(wr_cnt - w0), 512'(1));

    // random valid gaps over two rows
    do_reset();
    w0 = wr_cnt;
    for (int i = 0; i < 128; i++) send(8'($urandom), i == 0, 2);
    drain("t4_queue");
    chk("t4_writes", 512'(wr_cnt - w0), 512'(2));

    // reset mid-row at plane 2 row 7 pixel 40
    do_reset();
    n5 = 2*1024 + 7*64 + 41;
    for (int i = 0; i < n5; i++) send(8'(i), i == 0, 0);
    drain("t5_pre_queue");
    w0 = wr_cnt;
    do_reset();
    repeat (3) @(negedge clk);
    chk("t5_no_partial", 512'(wr_cnt - w0), 512'(0));
    for (int i = 0; i < 64; i++) send(8'(i + 3), i == 0, 0);
    drain("t5_queue");
    chk("t5_writes", 512'(wr_cnt - w0), 512'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hub_row_loader.md
Name: hub_row_loader

Overview:
Write-side companion to the HUB75 scan driver. Accepts a byte-wide pixel stream over a valid/ready handshake and assembles 64-pixel rows. Commits each completed row as one full-width word into the per-colour-plane pixel RAM write ports (one-hot wen, shared waddr/wdata). Sits between the frame source and the six pixel RAMs: R1, G1, B1, R2, G2, B2.

Parameters:
COLOR_BITS, 8, bits per pixel per colour plane
ROW_ADDR_BITS, 6, log2 pixels per row (64)
COL_ADDR_BITS, 4, log2 rows per plane (16)
PLANES, 6, number of pixel RAMs (DISP_COUNT*3); need not be a power of 2

Ports:
clk  in  1  system clock (25 MHz domain of the scan driver)
rst  in  1  asynchronous, active-high reset
in_data  in  COLOR_BITS  pixel intensity byte
in_valid  in  1  in_data valid
in_sof  in  1  qualifies the current byte as pixel 0, row 0, plane 0 of a frame
in_ready  out  1  loader accepts a byte this cycle
ram_wen  out  PLANES  one-hot write enable, bit k = plane k
ram_waddr  out  COL_ADDR_BITS  row address of the write
ram_wdata  out  2**ROW_ADDR_BITS*COLOR_BITS  assembled row; pixel p at bits [COLOR_BITS*p+COLOR_BITS-1 : COLOR_BITS*p]
frame_done  out  1  one-cycle pulse on commit of the final row of the final plane
sof_err  out  1  one-cycle pulse when in_sof is accepted off-alignment

Behaviour:
- Transfer: a byte is accepted when in_valid && in_ready at the clk rising edge. in_data/in_sof are ignored otherwise.
- Stream order is plane-major, then row 0..15, then pixel 0..63.
- Counters: pix_cnt (ROW_ADDR_BITS), row_cnt (COL_ADDR_BITS), plane_cnt (0..PLANES-1).
  - pix_cnt wraps at 63 and increments row_cnt.
  - row_cnt wraps at 15 and increments plane_cnt.
  - plane_cnt wraps explicitly from PLANES-1 to 0.
- States: FILL and COMMIT.
  - FILL: in_ready=1. The accepted byte is written into row buffer slot pix_cnt. Accepting pixel 63 moves to COMMIT.
  - COMMIT: lasts exactly 1 cycle. ram_wen = (1<<plane_cnt of the completed row), ram_waddr = its row_cnt, ram_wdata = buffer. in_ready=0. Returns to FILL next cycle.
- Latency: the write is asserted the cycle after pixel 63 is accepted, for exactly 1 cycle. Outside COMMIT, ram_wen=0.
- ram_wdata/ram_waddr are don't-care when ram_wen=0, but are held stable (registered).
- frame_done pulses in the same cycle as the COMMIT of plane PLANES-1, row 15.
- in_sof handling: an accepted byte with in_sof=1 forces its position to plane 0, row 0, pixel 0 and is stored as pixel 0.
  - If the counters were not all zero at that moment, the partial row is discarded (never written) and sof_err pulses 1 cycle later.
  - An aligned SOF produces no error.
- Stream before the first SOF after reset is accepted from position 0/0/0.
- Reset (async, any state including mid-row or COMMIT):
  - in_ready=0 while rst is high, 1 on the first cycle after release.
  - ram_wen=0, frame_done=0, sof_err=0.
  - Counters zeroed; buffer contents irrelevant.
  - An interrupted row is never written.
- Back-to-back throughput without the option: 64 bytes per 65 cycles.

Optional Feature:
Macro HUB_ROW_LOADER_DOUBLE_BUFFER_EN.
- Defined: two row buffers. On acceptance of pixel 63 the filled buffer is handed to a commit stage, and filling continues into the other buffer in the very next cycle. in_ready stays 1 continuously in the absence of reset, giving 64 bytes per 64 cycles. Write timing (cycle after pixel 63), frame_done and addressing are unchanged.
- A SOF accepted in the commit cycle does not cancel the pending commit, because that row was complete.
- Undefined: single buffer; 1-cycle in_ready bubble per row as in Behaviour.

Test Plan:
- Reset release, then 64 bytes 0x00..0x3F with in_valid held high, SOF on first -> one cycle later ram_wen=6'b000001, ram_waddr=0, ram_wdata[7:0]=0x00, ram_wdata[511:504]=0x3F; in_ready=0 that cycle (1 with DOUBLE_BUFFER_EN); no sof_err.
- Full frame 6*16*64=6144 bytes of 0xA5 -> 96 writes; wen walks bit0..bit5, waddr 0..15 within each; frame_done exactly once, coincident with wen=6'b100000, waddr=15.
- 10 bytes, then a SOF byte 0x77, then 63 bytes -> no write for the partial row; sof_err pulse once; next write is plane 0 row 0 with wdata[7:0]=0x77.
- Random in_valid gaps (≈50% duty) over 2 rows -> data identical to the gap-free case; no byte lost or duplicated while in_ready=0.
- Assert rst after pixel 40 of plane 2 row 7, then restart a frame -> ram_wen never asserts for that row; outputs at reset values during rst; next frame writes plane 0 row 0 first.
- Continuous frame with HUB_ROW_LOADER_DOUBLE_BUFFER_EN -> in_ready never deasserts; frame completes in 6144 accept cycles + 1.
